msl_multi_sender: RTL and testbench

MSL_MULTI_SENDER -- requirements
Module: msl_multi_sender

---
 rtl/msl_multi_sender.sv | 178 +++++++++++++++++
 tb/tb_msl_multi_sender.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/msl_multi_sender.sv
// Multi-channel MSL frame sender: one channel per slot, round-robin, with shadow
// registers so host updates never corrupt a frame that is already on the line.
module msl_multi_sender #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_CH_NUM     = 4,
    parameter int P_SYSTEM_CLK = 1000,
    parameter int P_BIT_CLKS   = 8,
    parameter int P_PARITY_EN  = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] i_data,
    input  logic                             i_load,
    output logic                             o_msl_sda,
    output logic                             o_msl_1ms,
    output logic [$clog2(P_CH_NUM)-1:0]      o_ch,
    output logic                             o_busy,
    output logic                             o_frame_done
);
    localparam int CHW = $clog2(P_CH_NUM);
    localparam int PW  = (P_PARITY_EN != 0) ? 1 : 0;
    localparam int FW  = CHW + P_DATA_WIDTH + PW;
    localparam int SW  = $clog2(P_SYSTEM_CLK + 1);
    localparam int BW  = $clog2(P_BIT_CLKS + 1);
    localparam int IW  = $clog2(FW + 1);

    localparam logic [SW-1:0]  SLOT_LAST = SW'(P_SYSTEM_CLK - 1);
    localparam logic [BW-1:0]  CLK_LAST  = BW'(P_BIT_CLKS - 1);
    localparam logic [IW-1:0]  ID_LAST   = IW'(CHW - 1);
    localparam logic [IW-1:0]  DATA_LAST = IW'(P_DATA_WIDTH - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(P_CH_NUM - 1);

    if (P_CH_NUM < 2 || P_CH_NUM > 16) begin : g_bad_ch_num
        $error("msl_multi_sender: P_CH_NUM must be 2..16");
    end
    if (P_BIT_CLKS < 1 || P_SYSTEM_CLK < P_BIT_CLKS * (3 + CHW + P_DATA_WIDTH + PW)) begin : g_bad_slot
        $error("msl_multi_sender: slot too short for one frame");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_ID, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           slot_q;
    logic [BW-1:0]           clk_q, clk_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           shift_q, shift_d;
    logic [CHW-1:0]          ch_d, ch_inc;
    logic [P_DATA_WIDTH-1:0] shadow_q [P_CH_NUM];
    logic [P_DATA_WIDTH-1:0] data_in  [P_CH_NUM];
    logic [P_DATA_WIDTH-1:0] data_sel;
    logic [FW-1:0]           load_word;
    logic                    bit_end, start, frame_end, slot_start;
    logic                    sda_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end
    end

    assign slot_start = (slot_q == '0);

    always_comb begin
        for (int k = 0; k < P_CH_NUM; k++) begin
            data_in[k] = i_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    end

    // NOTE: shadows are a small register file, not RAM, so clearing them on reset is cheap and well defined.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < P_CH_NUM; k++) shadow_q[k] <= '0;
        end else if (i_load) begin
            for (int k = 0; k < P_CH_NUM; k++) shadow_q[k] <= data_in[k];
        end
    end

    assign ch_inc = (o_ch == CH_LAST) ? '0 : o_ch + CHW'(1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        clk_d     = clk_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        ch_d      = o_ch;
        start     = 1'b0;
        frame_end = 1'b0;
        bit_end   = (clk_q == CLK_LAST);

        if (state_q != S_IDLE) begin
            clk_d = bit_end ? '0 : clk_q + BW'(1);
            if (bit_end) idx_d = idx_q + IW'(1);
        end

        unique case (state_q)
            S_IDLE:  start = slot_start;
            S_START: if (bit_end && idx_q == IW'(1)) begin
                state_d = S_ID;
                idx_d   = '0;
            end
            S_ID: if (bit_end) begin
                shift_d = shift_q << 1;
                if (idx_q == ID_LAST) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: if (bit_end) begin
                shift_d = shift_q << 1;
                if (idx_q == DATA_LAST) begin
                    state_d = (PW != 0) ? S_PARITY : S_STOP;
                    idx_d   = '0;
                end
            end
            S_PARITY: if (bit_end) begin
                shift_d = shift_q << 1;
                state_d = S_STOP;
                idx_d   = '0;
            end
            S_STOP: if (bit_end) begin
                state_d   = S_IDLE;
                idx_d     = '0;
                frame_end = 1'b1;
                ch_d      = ch_inc;
                // A frame that exactly fills the slot ends on the next slot-start edge.
                start     = slot_start;
            end
            default: state_d = S_IDLE;
        endcase

        // A load on the slot-start edge is forwarded straight into the frame.
        data_sel  = i_load ? data_in[ch_d] : shadow_q[ch_d];
        load_word = '0;
        load_word[FW-1 -: CHW+P_DATA_WIDTH] = {ch_d, data_sel};
        if (PW != 0) load_word[0] = ^{ch_d, data_sel};

        if (start) begin
            state_d = S_START;
            clk_d   = '0;
            idx_d   = '0;
            shift_d = load_word;
        end

        unique case (state_d)
            S_START:                 sda_d = 1'b0;
            S_ID, S_DATA, S_PARITY:  sda_d = shift_d[FW-1];
            default:                 sda_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            clk_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            o_ch         <= '0;
            o_msl_sda    <= 1'b1;
            o_msl_1ms    <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_q        <= clk_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            o_ch         <= ch_d;
            o_msl_sda    <= sda_d;
            o_msl_1ms    <= start;
            o_busy       <= (state_d != S_IDLE);
            o_frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_msl_multi_sender.sv
// Directed bench for msl_multi_sender: frame decode, slot timing, loads, reset abort,
// plus a parity-disabled instance for frame length.
module tb_msl_multi_sender;
    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [127:0] i_data;
    logic         i_load;
    logic         o_msl_sda, o_msl_1ms, o_busy, o_frame_done;
    logic [1:0]   o_ch;
    logic         np_sda, np_1ms, np_busy, np_done;
    logic [1:0]   np_ch;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_pulse = 0;

    msl_multi_sender dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_load(i_load),
        .o_msl_sda(o_msl_sda), .o_msl_1ms(o_msl_1ms), .o_ch(o_ch),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    msl_multi_sender #(.P_PARITY_EN(0)) dut_np (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_load(i_load),
        .o_msl_sda(np_sda), .o_msl_1ms(np_1ms), .o_ch(np_ch),
        .o_busy(np_busy), .o_frame_done(np_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a slot pulse, then checks one full frame cycle by cycle and decodes it mid-bit.
    task automatic frame_check(input string tag, input logic [1:0] ch, input logic [31:0] data,
                               input bit chk_per, input int load_at, input logic [127:0] load_vec,
                               output int waited, output logic par_bit);
        logic [37:0] exp_bits;
        logic [37:0] rx;
        logic [1:0]  nch;
        int          bad;
        exp_bits = {2'b00, ch, data, ^{ch, data}, 1'b1};
        nch      = ch + 2'd1;
        rx       = '0;
        bad      = 0;
        waited   = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (o_msl_1ms !== 1'b1 && waited < 1100);
        check({tag, ".pulse"}, o_msl_1ms, 1);
        if (chk_per) check({tag, ".period"}, cyc - last_pulse, 1000);
        last_pulse = cyc;
        check({tag, ".ch"}, o_ch, ch);
        for (int c = 0; c < 304; c++) begin
            if (c > 0) begin
                @(negedge i_clk);
                if (o_msl_1ms !== 1'b0) bad++;
            end
            if (o_msl_sda !== exp_bits[37 - c/8]) bad++;
            if (o_busy !== 1'b1 || o_frame_done !== 1'b0) bad++;
            if (c % 8 == 4) rx[37 - c/8] = o_msl_sda;
            i_load = (c == load_at);
            if (c == load_at) i_data = load_vec;
        end
        @(negedge i_clk);
        i_load = 1'b0;
        check({tag, ".done"},     o_frame_done, 1);
        check({tag, ".busy_off"}, o_busy, 0);
        check({tag, ".sda_idle"}, o_msl_sda, 1);
        check({tag, ".ch_next"},  o_ch, nch);
        check({tag, ".bad_cycles"}, bad, 0);
        check({tag, ".rx_id"},    rx[35:34], ch);
        check({tag, ".rx_data"},  rx[33:2], data);
        par_bit = rx[1];
    endtask

    initial begin
        int          waited, np_cnt, np_done_at;
        logic        par, np_s285;
        logic [1:0]  ch_model;
        logic [31:0] sm [4];
        logic [127:0] vec;
        int          load_at;

        i_rst  = 1'b1;
        i_load = 1'b0;
        i_data = '0;
        repeat (3) @(negedge i_clk);
        check("rst.sda",  o_msl_sda, 1);
        check("rst.1ms",  o_msl_1ms, 0);
        check("rst.busy", o_busy, 0);
        check("rst.done", o_frame_done, 0);
        check("rst.ch",   o_ch, 0);

        // Release with a load on the first slot-start edge: frame uses the new data.
        i_data = {32'h33333333, 32'h22222222, 32'h00000001, 32'h12345678};
        i_rst  = 1'b0;
        i_load = 1'b1;
        frame_check("f0", 2'd0, 32'h12345678, 1'b0, -1, '0, waited, par);
        check("f0.latency", waited, 1);
        check("f0.parity", par, 1);

        frame_check("f1", 2'd1, 32'h00000001, 1'b1, -1, '0, waited, par);
        check("f1.parity", par, 0);

        // Parity-disabled instance: same slot, frame shortened by one bit.
        waited = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (np_1ms !== 1'b1 && waited < 1100);
        check("np.pulse", np_1ms, 1);
        last_pulse = cyc;
        np_cnt = 0;
        np_done_at = -1;
        np_s285 = 1'bx;
        for (int c = 0; c < 320; c++) begin
            if (c > 0) @(negedge i_clk);
            if (np_busy === 1'b1) np_cnt++;
            if (np_done === 1'b1 && np_done_at < 0) np_done_at = c;
            if (c == 285) np_s285 = np_sda;
        end
        check("np.busy_len", np_cnt, 296);
        check("np.done_at", np_done_at, 296);
        check("np.data_lsb", np_s285, 0);

        // Load all channels in idle and walk the round-robin through the wrap.
        i_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        i_load = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        frame_check("rr3", 2'd3, 32'h44444444, 1'b1, -1, '0, waited, par);
        frame_check("rr0", 2'd0, 32'h11111111, 1'b1, -1, '0, waited, par);
        frame_check("rr1", 2'd1, 32'h22222222, 1'b1, -1, '0, waited, par);
        frame_check("rr2", 2'd2, 32'h33333333, 1'b1, -1, '0, waited, par);

        // Mid-frame load leaves the frame alone; the next slot carries the new value.
        frame_check("mid", 2'd3, 32'h44444444, 1'b1, 100,
                    {32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h80000001}, waited, par);
        frame_check("mid_next", 2'd0, 32'h80000001, 1'b1, -1, '0, waited, par);

        // Load exactly on the slot-start edge (cycle 999 after the last pulse).
        repeat (695) @(negedge i_clk);
        i_data = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'hDEADBEEF, 32'h80000001};
        i_load = 1'b1;
        frame_check("byp", 2'd1, 32'hDEADBEEF, 1'b1, -1, '0, waited, par);
        check("byp.latency", waited, 1);

        // Reset 100 cycles into the channel-2 frame.
        waited = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (o_msl_1ms !== 1'b1 && waited < 1100);
        check("abort.pulse", o_msl_1ms, 1);
        check("abort.ch", o_ch, 2);
        repeat (99) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort.sda",  o_msl_sda, 1);
        check("abort.busy", o_busy, 0);
        check("abort.done", o_frame_done, 0);
        check("abort.ch0",  o_ch, 0);
        @(negedge i_clk);
        check("abort.done2", o_frame_done, 0);
        i_rst = 1'b0;
        frame_check("rst_f", 2'd0, 32'h00000000, 1'b0, -1, '0, waited, par);
        check("rst_f.latency", waited, 1);

        // Random slots against a shadow-register model.
        for (int k = 0; k < 4; k++) sm[k] = '0;
        ch_model = 2'd1;
        for (int s = 0; s < 12; s++) begin
            vec = {$urandom, $urandom, $urandom, $urandom};
            load_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 303)) : -1;
            frame_check("rnd", ch_model, sm[ch_model], 1'b1, load_at, vec, waited, par);
            if (load_at >= 0) begin
                for (int k = 0; k < 4; k++) sm[k] = vec[k*32 +: 32];
            end
            ch_model = ch_model + 2'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
